// File: rtl/latch_bank_sync.sv
// Bank of CHANNELS hold registers with per-channel lock and sticky change flags, plus a one-entry snapshot buffer.
// Latency: en->q and snap_req->snap_valid are one cycle. Backpressure: snap_ready=0 freezes snap_data; new requests are dropped into snap_overrun.
module latch_bank_sync #(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       lock_set,
    input  logic [CHANNELS-1:0]       lock_clr,
    input  logic [CHANNELS-1:0]       changed_clr,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       locked,
    output logic [CHANNELS-1:0]       changed,
    input  logic                      snap_req,
    output logic                      snap_valid,
    input  logic                      snap_ready,
    output logic [CHANNELS*WIDTH-1:0] snap_data,
    output logic                      snap_overrun
);

    typedef enum logic {SNAP_EMPTY, SNAP_FULL} snap_state_t;

    snap_state_t         state_q, state_d;
    logic [CHANNELS-1:0] load;
    logic [CHANNELS-1:0] differs;
    logic                capture;
    logic                overrun_set;

    // The lock is sampled pre-edge, so a same-cycle lock_set still lets the load through.
    assign load = en & ~locked;

    always_comb begin
        differs = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            differs[i] = data[i*WIDTH +: WIDTH] != q[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q       <= {CHANNELS{RST_VAL}};
            locked  <= '0;
            changed <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load[i]) begin
                    q[i*WIDTH +: WIDTH] <= data[i*WIDTH +: WIDTH];
                end
                if (lock_set[i]) begin
                    locked[i] <= 1'b1;
                end else if (lock_clr[i]) begin
                    locked[i] <= 1'b0;
                end
                if (load[i] && differs[i]) begin
                    changed[i] <= 1'b1;
                end else if (changed_clr[i]) begin
                    changed[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            SNAP_EMPTY: begin
                if (snap_req) begin
                    capture = 1'b1;
                    state_d = SNAP_FULL;
                end
            end
            SNAP_FULL: begin
                if (snap_ready) begin
                    if (snap_req) begin
                        capture = 1'b1;
                    end else begin
                        state_d = SNAP_EMPTY;
                    end
                end else if (snap_req) begin
                    overrun_set = 1'b1;
                end
            end
            default: state_d = SNAP_EMPTY;
        endcase
    end

    // Capture takes pre-edge q, so a same-cycle load shows up only in the next snapshot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SNAP_EMPTY;
            snap_data    <= '0;
            snap_overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                snap_data <= q;
            end
            if (overrun_set) begin
                snap_overrun <= 1'b1;
            end
        end
    end

    assign snap_valid = (state_q == SNAP_FULL);

endmodule

// File: tb/tb_latch_bank_sync.sv
// Bench for latch_bank_sync: directed scenarios plus a randomised scoreboard run.
module tb_latch_bank_sync;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic [3:0]  en, lock_set, lock_clr, changed_clr;
    logic [31:0] q;
    logic [3:0]  locked, changed;
    logic        snap_req, snap_valid, snap_ready, snap_overrun;
    logic [31:0] snap_data;

    typedef struct packed {
        logic [31:0] q;
        logic [3:0]  locked;
        logic [3:0]  changed;
        logic        sv;
        logic [31:0] sd;
        logic        ov;
    } exp_t;

    exp_t sbq[$];
    exp_t m;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    latch_bank_sync #(.WIDTH(8), .CHANNELS(4), .RST_VAL(RV)) dut (
        .clk(clk), .reset(reset), .data(data), .en(en),
        .lock_set(lock_set), .lock_clr(lock_clr), .changed_clr(changed_clr),
        .q(q), .locked(locked), .changed(changed),
        .snap_req(snap_req), .snap_valid(snap_valid), .snap_ready(snap_ready),
        .snap_data(snap_data), .snap_overrun(snap_overrun)
    );

    // Drives one cycle, pushes the reference result, then waits past the edge.
    task automatic drive(input logic rst, input logic [31:0] d, input logic [3:0] e,
                         input logic [3:0] ls, input logic [3:0] lc, input logic [3:0] cc,
                         input logic sr, input logic rdy);
        exp_t x;
        logic ld;
        reset = rst; data = d; en = e; lock_set = ls; lock_clr = lc;
        changed_clr = cc; snap_req = sr; snap_ready = rdy;
        x = m;
        if (!rst) begin
            x.q = {4{RV}}; x.locked = '0; x.changed = '0;
            x.sv = 1'b0; x.sd = '0; x.ov = 1'b0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                ld = e[c] && !m.locked[c];
                if (ld) x.q[c*8 +: 8] = d[c*8 +: 8];
                x.locked[c]  = ls[c] ? 1'b1 : (lc[c] ? 1'b0 : m.locked[c]);
                x.changed[c] = (ld && d[c*8 +: 8] != m.q[c*8 +: 8]) ? 1'b1 :
                               (cc[c] ? 1'b0 : m.changed[c]);
            end
            if (!m.sv) begin
                if (sr) begin x.sv = 1'b1; x.sd = m.q; end
            end else if (rdy) begin
                if (sr) x.sd = m.q; else x.sv = 1'b0;
            end else if (sr) begin
                x.ov = 1'b1;
            end
        end
        sbq.push_back(x);
        m = x;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        e = sbq.pop_front();
        drive(0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (q !== 32'hA5A5A5A5) $display("FAIL reset_q got %h exp %h", q, 32'hA5A5A5A5); else n_pass++;
        n_checks++; if ({locked, changed} !== 8'h00) $display("FAIL reset_flags got %h exp 00", {locked, changed}); else n_pass++;
        n_checks++; if ({snap_valid, snap_overrun} !== 2'b00) $display("FAIL reset_snap got %b exp 00", {snap_valid, snap_overrun}); else n_pass++;
        n_checks++; if (snap_data !== 32'h0) $display("FAIL reset_snap_data got %h exp 0", snap_data); else n_pass++;
    endtask

    task automatic test_load();
        exp_t e;
        drive(1, 32'h00003C00, 4'b0010, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (q !== 32'hA5A53CA5) $display("FAIL load_q got %h exp %h", q, 32'hA5A53CA5); else n_pass++;
        n_checks++; if (q !== e.q) $display("FAIL load_q_sb got %h exp %h", q, e.q); else n_pass++;
        n_checks++; if (changed !== 4'b0010) $display("FAIL load_changed got %b exp 0010", changed); else n_pass++;
    endtask

    task automatic test_lock();
        exp_t e;
        drive(1, 32'h00000011, 4'b0001, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (q[7:0] !== 8'h11) $display("FAIL lock_same_cycle_load got %h exp 11", q[7:0]); else n_pass++;
        n_checks++; if (locked !== 4'b0001) $display("FAIL lock_set got %b exp 0001", locked); else n_pass++;
        drive(1, 32'h00000022, 4'b0001, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (q[7:0] !== 8'h11) $display("FAIL lock_blocks_load got %h exp 11", q[7:0]); else n_pass++;
        drive(1, 32'h0, 4'h0, 4'h0, 4'b0001, 4'h0, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (locked !== 4'b0000) $display("FAIL lock_clr got %b exp 0000", locked); else n_pass++;
        drive(1, 32'h00000022, 4'b0001, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (q[7:0] !== 8'h22) $display("FAIL unlock_load got %h exp 22", q[7:0]); else n_pass++;
    endtask

    task automatic test_changed();
        exp_t e;
        drive(1, 32'h00A50000, 4'b0100, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (changed[2] !== 1'b0) $display("FAIL changed_equal got %b exp 0", changed[2]); else n_pass++;
        drive(1, 32'h00010000, 4'b0100, 4'h0, 4'h0, 4'b0100, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (changed[2] !== 1'b1) $display("FAIL changed_set_wins got %b exp 1", changed[2]); else n_pass++;
        drive(1, 32'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (changed[2] !== 1'b0) $display("FAIL changed_clr got %b exp 0", changed[2]); else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        drive(1, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (snap_valid !== 1'b1) $display("FAIL snap_valid_set got %b exp 1", snap_valid); else n_pass++;
        n_checks++; if (snap_data !== 32'hA5013C22) $display("FAIL snap_capture got %h exp %h", snap_data, 32'hA5013C22); else n_pass++;
        drive(1, 32'h44332211, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (q !== 32'h44332211) $display("FAIL load_all got %h exp %h", q, 32'h44332211); else n_pass++;
        drive(1, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        e = sbq.pop_front();
        n_checks++; if (snap_data !== 32'hA5013C22) $display("FAIL snap_frozen got %h exp %h", snap_data, 32'hA5013C22); else n_pass++;
        n_checks++; if (snap_overrun !== 1'b1) $display("FAIL snap_overrun got %b exp 1", snap_overrun); else n_pass++;
        drive(1, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        e = sbq.pop_front();
        n_checks++; if (snap_valid !== 1'b0) $display("FAIL snap_drain got %b exp 0", snap_valid); else n_pass++;
        n_checks++; if (snap_data !== e.sd) $display("FAIL snap_hold_after_drain got %h exp %h", snap_data, e.sd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] cur, lag;
        for (int k = 0; k < 4; k++) begin
            cur = 8'(8'h50 + k);
            lag = (k == 0) ? 8'h44 : 8'(8'h50 + k - 1);
            drive(1, {cur, 24'h0}, 4'b1000, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
            e = sbq.pop_front();
            n_checks++; if (q[31:24] !== cur) $display("FAIL b2b_q[%0d] got %h exp %h", k, q[31:24], cur); else n_pass++;
            n_checks++; if (snap_data[31:24] !== lag) $display("FAIL b2b_lag[%0d] got %h exp %h", k, snap_data[31:24], lag); else n_pass++;
            n_checks++; if (snap_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b exp 1", k, snap_valid); else n_pass++;
            n_checks++; if (snap_data !== e.sd) $display("FAIL b2b_sd_sb[%0d] got %h exp %h", k, snap_data, e.sd); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(1, ~m.q, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        e = sbq.pop_front();
        n_checks++; if ({locked, changed, snap_valid} !== 9'h1FF) $display("FAIL pre_reset_state got %h exp 1ff", {locked, changed, snap_valid}); else n_pass++;
        drive(0, 32'h12345678, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1);
        e = sbq.pop_front();
        n_checks++; if (q !== 32'hA5A5A5A5) $display("FAIL mid_reset_q got %h exp %h", q, 32'hA5A5A5A5); else n_pass++;
        n_checks++; if ({locked, changed, snap_valid, snap_overrun} !== 10'h0) $display("FAIL mid_reset_flags got %h exp 0", {locked, changed, snap_valid, snap_overrun}); else n_pass++;
        n_checks++; if (snap_data !== 32'h0) $display("FAIL mid_reset_snap_data got %h exp 0", snap_data); else n_pass++;
    endtask

    task automatic test_random();
        exp_t e;
        logic rst;
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 49) != 0);
            drive(rst, $urandom, 4'($urandom), 4'($urandom & $urandom & $urandom), 4'($urandom),
                  4'($urandom), 1'($urandom), 1'($urandom));
            e = sbq.pop_front();
            n_checks++;
            if ({q, locked, changed, snap_valid, snap_data, snap_overrun} !== e)
                $display("FAIL random[%0d] got %h exp %h", n, {q, locked, changed, snap_valid, snap_data, snap_overrun}, e);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0; data = '0; en = '0; lock_set = '0; lock_clr = '0;
        changed_clr = '0; snap_req = 1'b0; snap_ready = 1'b0;
        #1;
        test_reset();
        test_load();
        test_lock();
        test_changed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
